// File: rtl/spk_out_arb_if.sv
// Flit-link bundle between the spike/config requesters, the output arbiter and the router side.
// The slave modport is the arbiter's view; master is the requester/router-side view.
interface spk_out_arb_if #(
  parameter int unsigned FW = 59,
  parameter int unsigned CW = 5
) ();

  logic          neu_req;
  logic [FW-1:0] neu_data;
  logic          neu_ack;
  logic          cfg_req;
  logic [FW-1:0] cfg_data;
  logic          cfg_ack;
  logic          credit_in;
  logic [FW-1:0] flit_out;
  logic          flit_out_wr;
  logic [CW-1:0] credit_cnt;
  logic          credit_err;

  modport slave (
    input  neu_req,
    input  neu_data,
    output neu_ack,
    input  cfg_req,
    input  cfg_data,
    output cfg_ack,
    input  credit_in,
    output flit_out,
    output flit_out_wr,
    output credit_cnt,
    output credit_err
  );

  modport master (
    output neu_req,
    output neu_data,
    input  neu_ack,
    output cfg_req,
    output cfg_data,
    input  cfg_ack,
    output credit_in,
    input  flit_out,
    input  flit_out_wr,
    input  credit_cnt,
    input  credit_err
  );

endinterface

// File: rtl/spk_out_arb.sv
// Output scheduler sharing the router flit link between neuron and config sources under credit flow control.
// Build option SPK_OUT_CFG_PRIO_EN: cfg wins every tie instead of round-robin.
module spk_out_arb #(
  parameter int unsigned FW      = 59,
  parameter int unsigned FTW     = 3,
  parameter int unsigned CW      = 5,
  parameter int unsigned CREDITS = 16
) (
  input  logic         clk_spk_out,
  input  logic         rst_n,
  spk_out_arb_if.slave bus
);

  localparam int unsigned PW = FW - FTW;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef enum logic {
    SRC_NEU = 1'b0,
    SRC_CFG = 1'b1
  } src_e;

  state_e         r_cs;
  state_e         w_ns;
  src_e           r_last_grant;
  logic [FW-1:0]  r_flit_out;
  logic [CW-1:0]  r_credit_cnt;
  logic           r_credit_err;

  logic           w_has_credit;
  logic           w_any_req;
  logic           w_grant_en;
  logic           w_grant_neu;
  logic           w_grant_cfg;
  logic           w_grant;
  logic           w_send;
  logic           w_at_max;
  logic [FW-1:0]  w_win_data;
  logic [FTW-1:0] w_win_type;
  logic [PW-1:0]  w_win_payload;

  assign w_has_credit = (r_credit_cnt != '0);
  assign w_any_req    = bus.neu_req | bus.cfg_req;
  assign w_at_max     = (r_credit_cnt == CW'(CREDITS));
  // Acks are combinational, so gate them off while reset is held.
  assign w_grant_en   = rst_n & (r_cs == IDLE) & w_has_credit;

  // Winner selection; only meaningful in IDLE with at least one credit.
  always_comb begin
    w_grant_neu = 1'b0;
    w_grant_cfg = 1'b0;
    if (w_grant_en) begin
`ifdef SPK_OUT_CFG_PRIO_EN
      w_grant_cfg = bus.cfg_req;
      w_grant_neu = bus.neu_req & ~bus.cfg_req;
`else
      if (bus.neu_req && bus.cfg_req) begin
        w_grant_neu = (r_last_grant == SRC_CFG);
        w_grant_cfg = (r_last_grant == SRC_NEU);
      end else begin
        w_grant_neu = bus.neu_req;
        w_grant_cfg = bus.cfg_req;
      end
`endif
    end
  end

  assign w_grant = w_grant_neu | w_grant_cfg;

  // Type field rides along untouched with the payload of the winning flit.
  always_comb begin
    w_win_data    = w_grant_cfg ? bus.cfg_data : bus.neu_data;
    w_win_type    = w_win_data[FW-1:PW];
    w_win_payload = w_win_data[PW-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_cs <= IDLE;
    end else begin
      r_cs <= w_ns;
    end
  end

  // FSM next state: one send cycle after every grant paces the link at one flit per two cycles.
  always_comb begin
    w_ns = r_cs;
    case (r_cs)
      IDLE: begin
        if (w_any_req && w_has_credit) begin
          w_ns = SEND;
        end
      end
      SEND: begin
        w_ns = IDLE;
      end
      default: begin
        w_ns = IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.neu_ack = w_grant_neu;
    bus.cfg_ack = w_grant_cfg;
    w_send      = (r_cs == SEND);
  end

  // Flit capture and round-robin history, updated only on a grant.
  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_out   <= '0;
      r_last_grant <= SRC_CFG;
    end else if (w_grant) begin
      r_flit_out   <= {w_win_type, w_win_payload};
      r_last_grant <= w_grant_cfg ? SRC_CFG : SRC_NEU;
    end
  end

  // Credit accounting: send consumes, credit_in returns; a return at full count is flagged and dropped.
  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_cnt <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      if (w_send && !bus.credit_in) begin
        r_credit_cnt <= r_credit_cnt - CW'(1);
      end else if (!w_send && bus.credit_in) begin
        if (w_at_max) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credit_cnt <= r_credit_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.flit_out    = r_flit_out;
  assign bus.flit_out_wr = w_send;
  assign bus.credit_cnt  = r_credit_cnt;
  assign bus.credit_err  = r_credit_err;

endmodule

// File: tb/tb_spk_out_arb.sv
// Scoreboard bench for spk_out_arb: random and directed traffic against a cycle-level reference model.
module tb_spk_out_arb;

  localparam int unsigned FW      = 59;
  localparam int unsigned FTW     = 3;
  localparam int unsigned CW      = 5;
  localparam int unsigned CREDITS = 16;

  logic clk;
  logic rst_n;

  spk_out_arb_if #(.FW(FW), .CW(CW)) bus ();

  spk_out_arb #(
    .FW(FW), .FTW(FTW), .CW(CW), .CREDITS(CREDITS)
  ) u_dut (
    .clk_spk_out(clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [FW-1:0] sb[$];

  // Reference model state
  int m_cred;
  bit m_busy;
  bit m_last_cfg;
  bit m_err;

  // Source state
  int neu_left;
  int cfg_left;
  bit hold_req;
  bit neu_acked;
  bit cfg_acked;
  int g_neu;
  int g_cfg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] rnd_flit();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  task automatic model_reset();
    m_cred     = CREDITS;
    m_busy     = 1'b0;
    m_last_cfg = 1'b1;
    m_err      = 1'b0;
    sb.delete();
    neu_acked  = 1'b0;
    cfg_acked  = 1'b0;
  endtask

  // Called at the negedge: compare this cycle against the model, then advance the model past the next edge.
  task automatic model_cycle();
    bit e_neu;
    bit e_cfg;
    bit nreq;
    bit creq;
    nreq  = bus.neu_req;
    creq  = bus.cfg_req;
    e_neu = 1'b0;
    e_cfg = 1'b0;
    if (!m_busy && m_cred > 0) begin
`ifdef SPK_OUT_CFG_PRIO_EN
      if (creq) e_cfg = 1'b1;
      else if (nreq) e_neu = 1'b1;
`else
      if (nreq && creq) begin
        if (m_last_cfg) e_neu = 1'b1;
        else e_cfg = 1'b1;
      end else begin
        e_neu = nreq;
        e_cfg = creq;
      end
`endif
    end
    chk("neu_ack", 64'(bus.neu_ack), 64'(e_neu));
    chk("cfg_ack", 64'(bus.cfg_ack), 64'(e_cfg));
    chk("flit_out_wr", 64'(bus.flit_out_wr), 64'(m_busy));
    chk("credit_cnt", 64'(bus.credit_cnt), 64'(m_cred));
    chk("credit_err", 64'(bus.credit_err), 64'(m_err));
    if (e_neu) begin
      sb.push_back(bus.neu_data);
      m_last_cfg = 1'b0;
    end
    if (e_cfg) begin
      sb.push_back(bus.cfg_data);
      m_last_cfg = 1'b1;
    end
    if (m_busy && !bus.credit_in) m_cred--;
    else if (!m_busy && bus.credit_in) begin
      if (m_cred == CREDITS) m_err = 1'b1;
      else m_cred++;
    end
    m_busy    = e_neu | e_cfg;
    neu_acked = bus.neu_ack;
    cfg_acked = bus.cfg_ack;
    g_neu += int'(bus.neu_ack);
    g_cfg += int'(bus.cfg_ack);
  endtask

  // Requesters: hold req until ack, present next flit the cycle after ack.
  task automatic drive(input bit cin);
    @(posedge clk);
    #1;
    if (neu_acked) begin
      neu_left--;
      if (neu_left > 0 && (hold_req || $urandom_range(3) != 0)) bus.neu_data = rnd_flit();
      else bus.neu_req = 1'b0;
    end else if (!bus.neu_req && neu_left > 0 && (hold_req || $urandom_range(1) == 1)) begin
      bus.neu_req  = 1'b1;
      bus.neu_data = rnd_flit();
    end
    if (cfg_acked) begin
      cfg_left--;
      if (cfg_left > 0 && (hold_req || $urandom_range(3) != 0)) bus.cfg_data = rnd_flit();
      else bus.cfg_req = 1'b0;
    end else if (!bus.cfg_req && cfg_left > 0 && (hold_req || $urandom_range(1) == 1)) begin
      bus.cfg_req  = 1'b1;
      bus.cfg_data = rnd_flit();
    end
    bus.credit_in = cin;
  endtask

  task automatic step(input bit cin);
    drive(cin);
    @(negedge clk);
    model_cycle();
  endtask

  task automatic do_reset();
    bus.neu_req   = 1'b0;
    bus.cfg_req   = 1'b0;
    bus.credit_in = 1'b0;
    neu_left      = 0;
    cfg_left      = 0;
    hold_req      = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_flit_out_wr", 64'(bus.flit_out_wr), 64'(0));
    chk("rst_credit_cnt", 64'(bus.credit_cnt), 64'(CREDITS));
    chk("rst_credit_err", 64'(bus.credit_err), 64'(0));
    chk("rst_flit_out", 64'(bus.flit_out), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    model_cycle();
  endtask

  // Monitor: every flit on the link must match the oldest granted flit.
  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (rst_n === 1'b1 && bus.flit_out_wr === 1'b1) begin
      if (sb.size() == 0) chk("flit_wr_without_grant", 64'(bus.flit_out_wr), 64'(0));
      else begin
        e = sb.pop_front();
        chk("flit_out", 64'(bus.flit_out), 64'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    n_pass        = 0;
    n_total       = 0;
    g_neu         = 0;
    g_cfg         = 0;
    rst_n         = 1'b0;
    bus.neu_req   = 1'b0;
    bus.cfg_req   = 1'b0;
    bus.neu_data  = '0;
    bus.cfg_data  = '0;
    bus.credit_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Single neuron flit with a fixed payload
    do_reset();
    @(posedge clk);
    #1;
    bus.neu_req  = 1'b1;
    bus.neu_data = FW'(64'hABC);
    neu_left     = 1;
    @(negedge clk);
    chk("t1_ack_cycle0", 64'(bus.neu_ack), 64'(1));
    model_cycle();
    step(1'b0);
    chk("t1_flit_abc", 64'(bus.flit_out), 64'h0ABC);
    chk("t1_wr_cycle1", 64'(bus.flit_out_wr), 64'(1));
    step(1'b0);
    chk("t1_credit_15", 64'(bus.credit_cnt), 64'(15));

    // Both sources saturating, no credits returned
    do_reset();
    hold_req = 1'b1;
    neu_left = 1000;
    cfg_left = 1000;
    g_neu    = 0;
    g_cfg    = 0;
    repeat (40) step(1'b0);
`ifdef SPK_OUT_CFG_PRIO_EN
    chk("sat_neu_grants", 64'(g_neu), 64'(0));
    chk("sat_cfg_grants", 64'(g_cfg), 64'(16));
`else
    chk("sat_neu_grants", 64'(g_neu), 64'(8));
    chk("sat_cfg_grants", 64'(g_cfg), 64'(8));
`endif
    chk("sat_credit_0", 64'(bus.credit_cnt), 64'(0));

    // One credit back at zero releases exactly one flit
    g_neu = 0;
    g_cfg = 0;
    step(1'b1);
    repeat (12) step(1'b0);
    chk("one_credit_one_grant", 64'(g_neu + g_cfg), 64'(1));
    chk("one_credit_back_to_0", 64'(bus.credit_cnt), 64'(0));

    // Send and credit return coinciding at count 7
    do_reset();
    hold_req = 1'b1;
    neu_left = 1000;
    hit      = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      bit cin;
      cin = m_busy && (m_cred == 7);
      step(cin);
      if (cin) hit = 1'b1;
    end
    step(1'b0);
    chk("wr_and_credit_at_7", 64'(bus.credit_cnt), 64'(7));

    // Credit return with full count on an idle link
    do_reset();
    step(1'b1);
    step(1'b0);
    chk("ovf_credit_16", 64'(bus.credit_cnt), 64'(CREDITS));
    chk("ovf_err_set", 64'(bus.credit_err), 64'(1));
    neu_left = 10;
    cfg_left = 10;
    for (int i = 0; i < 80; i++) step(m_cred < CREDITS && $urandom_range(2) == 0);
    chk("ovf_err_sticky", 64'(bus.credit_err), 64'(1));

    // Reset during the send cycle
    do_reset();
    hold_req = 1'b1;
    neu_left = 50;
    cfg_left = 50;
    for (int i = 0; i < 10 && !m_busy; i++) step(1'b0);
    chk("mid_rst_reached_grant", 64'(bus.neu_ack | bus.cfg_ack), 64'(1));
    @(posedge clk);
    #3;
    chk("mid_rst_wr_before", 64'(bus.flit_out_wr), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_drop", 64'(bus.flit_out_wr), 64'(0));
    chk("mid_rst_credit", 64'(bus.credit_cnt), 64'(CREDITS));
    model_reset();
    @(negedge clk);
    chk("mid_rst_no_ack", 64'(bus.neu_ack | bus.cfg_ack), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SPK_OUT_CFG_PRIO_EN
    chk("mid_rst_first_tie", 64'(bus.cfg_ack), 64'(1));
`else
    chk("mid_rst_first_tie", 64'(bus.neu_ack), 64'(1));
`endif
    model_cycle();
    repeat (6) step(1'b0);

    // Random traffic with legal credit returns
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (neu_left <= 0 && $urandom_range(7) == 0) neu_left = int'($urandom_range(20, 1));
      if (cfg_left <= 0 && $urandom_range(7) == 0) cfg_left = int'($urandom_range(20, 1));
      if (i % 100 == 0) hold_req = bit'($urandom_range(1));
      step(m_cred < CREDITS && $urandom_range(2) == 0);
    end

    // Drain and return every outstanding credit
    hold_req = 1'b0;
    neu_left = 0;
    cfg_left = 0;
    for (int i = 0; i < 300; i++) step(m_cred < CREDITS && $urandom_range(1) == 0);
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    chk("drain_credit_full", 64'(bus.credit_cnt), 64'(CREDITS));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
